fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hazard hold: IF/ID register and fetch sequence freeze.
REQ-005 flush  input  1  insert bubble into IF/ID at next edge.
REQ-006 branch_taken  input  1  redirect to branch_target.
REQ-007 branch_target  input  32  resolved branch address.
REQ-008 jump  input  1  J-type redirect (j/jal).
REQ-009 jump_index  input  26  instr_index field of J-type instruction in ID.
REQ-010 r_jump  input  1  register redirect (jr/jalr).
REQ-011 jr_target  input  32  rs value for jr/jalr.
REQ-012 imem_req  output  1  instruction memory request.
REQ-013 imem_addr  output  32  fetch address; stable while imem_req high and imem_ready low.
REQ-014 imem_rdata  input  32  instruction word, valid only in a cycle with imem_ready=1.
REQ-015 imem_ready  input  1  request completes this cycle.
REQ-016 if_id_instr  output  32  registered instruction to decode.
REQ-017 if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-018 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-019 opcode / funct / rt  output  6/6/5  combinational slices [31:26]/[5:0]/[20:16] of if_id_instr, feeding the control unit.

Function
REQ-020 States SHALL be IDLE, FETCH, HOLD, DISCARD; IDLE lasts exactly one cycle after reset, then FETCH.
REQ-021 imem_req SHALL be 1 in FETCH and DISCARD, 0 in IDLE and HOLD; imem_addr = pc in FETCH, = address of the dropped request in DISCARD.
REQ-022 FETCH, imem_ready=1, no stall, no redirect: IF/ID <= {imem_rdata, pc+4, valid=1}, pc <= pc+4, stay FETCH; one instruction per cycle when imem_ready is held high.
REQ-023 FETCH, imem_ready=1, stall=1, no redirect: rdata captured in hold buffer, pc <= pc+4, go HOLD; IF/ID unchanged.
REQ-024 HOLD, stall=0: IF/ID <= {buffer, buffered pc+4, valid=1}, go FETCH.
REQ-025 Redirect priority: r_jump > jump > branch_taken; jump target = {if_id_pc4[31:28], jump_index, 2'b00}.
REQ-026 Redirect in any state SHALL load pc with target at next edge, even with stall=1.
REQ-027 Redirect in FETCH with imem_ready=0: go DISCARD; request held until ready, that response dropped, then FETCH at new pc.
REQ-028 Redirect in FETCH with imem_ready=1, or in HOLD: response/buffer dropped, go FETCH at new pc.
REQ-029 flush SHALL force if_id_instr=0, if_id_valid=0 at next edge, overriding stall and any load; if_id_pc4 unchanged.
REQ-030 stall=1 and flush=0: IF/ID SHALL hold its value.
REQ-031 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-032 On rst: state IDLE, pc=RESET_PC, imem_req=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, hold buffer cleared; asserting rst mid-request abandons it with no DISCARD.

Structure
REQ-033 State encodings, RESET_PC default and NOP (32'h0) SHALL live in a shared header included by datapath stages.
REQ-034 Next-PC selection SHALL be a combinational sub-module next_pc_sel (inputs pc, if_id_pc4, redirect controls and targets; output next pc).

Verification
REQ-035 Reset release, imem_ready=1 constant -> imem_addr 0,4,8,... on consecutive cycles; if_id_valid=1 from cycle 2.
REQ-036 stall during ready at addr 0x10 (rdata 0x8C010004) -> IF/ID held, HOLD entered; stall release -> if_id_instr=0x8C010004, if_id_pc4=0x14.
REQ-037 branch_taken=1, target 0x40, imem_ready=0 -> DISCARD; late response dropped; next imem_addr=0x40.
REQ-038 jump and r_jump together, jr_target=0x100 -> pc=0x100; jump alone, if_id_pc4=0x1000_0008, index=0x10 -> pc=0x1000_0040.
REQ-039 flush with stall=1 -> if_id_instr=0, opcode=0, funct=0, if_id_valid=0 next cycle.
REQ-040 rst asserted while FETCH with imem_ready=0 -> outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch datapath: FSM states, reset PC, NOP word.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_stage_next_pc.sv
// Combinational next-PC mux: r_jump > jump > branch_taken, else sequential/hold.
import fetch_stage_pkg::*;

module next_pc_sel (
  input  logic [31:0] pc,
  input  logic [31:0] if_id_pc4,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        r_jump,
  input  logic [31:0] jr_target,
  output logic        redirect,
  output logic [31:0] next_pc
);

  always_comb begin
    redirect = r_jump | jump | branch_taken;
    next_pc  = pc;
    if (r_jump) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = {if_id_pc4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else if (advance) begin
      next_pc = pc_inc(pc);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake and the IF/ID register.
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump,
  input  logic [25:0]          jump_index,
  input  logic                 r_jump,
  input  logic [31:0]          jr_target,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc4,
  output logic                 if_id_valid,
  output logic [5:0]           opcode,
  output logic [5:0]           funct,
  output logic [4:0]           rt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc4_q, hold_pc4_d;
  logic [31:0]  discard_addr_q, discard_addr_d;
  logic [31:0]  if_id_instr_q, if_id_instr_d;
  logic [31:0]  if_id_pc4_q, if_id_pc4_d;
  logic         if_id_valid_q, if_id_valid_d;
  logic         advance;
  logic         redirect;

  next_pc_sel u_next_pc_sel (
    .pc            (pc_q),
    .if_id_pc4     (if_id_pc4_q),
    .advance       (advance),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .r_jump        (r_jump),
    .jr_target     (jr_target),
    .redirect      (redirect),
    .next_pc       (pc_d)
  );

  always_comb begin
    state_d        = state_q;
    advance        = 1'b0;
    hold_instr_d   = hold_instr_q;
    hold_pc4_d     = hold_pc4_q;
    discard_addr_d = discard_addr_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_pc4_d    = if_id_pc4_q;
    if_id_valid_d  = if_id_valid_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem.imem_req = 1'b1;
        if (redirect) begin
          // An unanswered request must still be completed before the bus is free
          if (!imem.imem_ready) begin
            state_d        = ST_DISCARD;
            discard_addr_d = pc_q;
          end
        end else if (imem.imem_ready) begin
          advance = 1'b1;
          if (stall) begin
            hold_instr_d = imem.imem_rdata;
            hold_pc4_d   = pc_inc(pc_q);
            state_d      = ST_HOLD;
          end else begin
            if_id_instr_d = imem.imem_rdata;
            if_id_pc4_d   = pc_inc(pc_q);
            if_id_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_FETCH;
        end else if (!stall) begin
          if_id_instr_d = hold_instr_q;
          if_id_pc4_d   = hold_pc4_q;
          if_id_valid_d = 1'b1;
          state_d       = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = discard_addr_q;
        if (imem.imem_ready) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      if_id_instr_d = NOP;
      if_id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      hold_instr_q   <= '0;
      hold_pc4_q     <= '0;
      discard_addr_q <= '0;
      if_id_instr_q  <= NOP;
      if_id_pc4_q    <= '0;
      if_id_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      hold_instr_q   <= hold_instr_d;
      hold_pc4_q     <= hold_pc4_d;
      discard_addr_q <= discard_addr_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_pc4_q    <= if_id_pc4_d;
      if_id_valid_q  <= if_id_valid_d;
    end
  end

  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign opcode      = if_id_instr_q[31:26];
  assign funct       = if_id_instr_q[5:0];
  assign rt          = if_id_instr_q[20:16];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an IF/ID scoreboard queue.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, branch_taken, jump, r_jump;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode, funct;
  logic [4:0]  rt;

  logic        ovr_en;
  logic [31:0] ovr_data;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;
  ifid_t sb[$];

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .r_jump        (r_jump),
    .jr_target     (jr_target),
    .imem          (bus),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .opcode        (opcode),
    .funct         (funct),
    .rt            (rt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus.imem_rdata = ovr_en ? ovr_data : mem_word(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    ifid_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, if_id_instr, e.instr);
      chk({tag, "_pc4"}, if_id_pc4, e.pc4);
      chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
      chk({tag, "_opcode"}, {26'd0, opcode}, {26'd0, e.instr[31:26]});
      chk({tag, "_funct"}, {26'd0, funct}, {26'd0, e.instr[5:0]});
      chk({tag, "_rt"}, {27'd0, rt}, {27'd0, e.instr[20:16]});
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; r_jump = 1'b0;
    branch_target = '0; jr_target = '0; jump_index = '0;
    ovr_en = 1'b0; ovr_data = '0;
    bus.imem_ready = 1'b0;
    step(); step();

    // Reset state
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_pc4", if_id_pc4, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);

    // Sequential streaming with ready held high
    rst = 1'b0; bus.imem_ready = 1'b1;
    #1 chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    for (int unsigned a = 0; a < 32'h10; a += 4) begin
      chk("seq_addr", bus.imem_addr, a);
      chk("seq_req", {31'd0, bus.imem_req}, 32'd1);
      sb.push_back('{instr: mem_word(a), pc4: a + 32'd4});
      step();
      pop_chk("seq");
    end

    // Stall while response arrives at 0x10
    chk("stall_addr", bus.imem_addr, 32'h10);
    ovr_en = 1'b1; ovr_data = 32'h8C01_0004; stall = 1'b1;
    step();
    ovr_en = 1'b0;
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("hold_instr", if_id_instr, mem_word(32'h0C));
    chk("hold_pc4", if_id_pc4, 32'h10);
    step();
    chk("hold2_instr", if_id_instr, mem_word(32'h0C));
    stall = 1'b0;
    sb.push_back('{instr: 32'h8C01_0004, pc4: 32'h14});
    step();
    pop_chk("unstall");
    chk("unstall_addr", bus.imem_addr, 32'h14);

    // Branch while request pending -> DISCARD
    bus.imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    chk("disc_addr", bus.imem_addr, 32'h14);
    chk("disc_req", {31'd0, bus.imem_req}, 32'd1);
    step();
    chk("disc2_addr", bus.imem_addr, 32'h14);
    bus.imem_ready = 1'b1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
    step();
    ovr_en = 1'b0;
    chk("disc_drop", if_id_instr, 32'h8C01_0004);
    chk("br_addr", bus.imem_addr, 32'h40);
    sb.push_back('{instr: mem_word(32'h40), pc4: 32'h44});
    step();
    pop_chk("br");

    // r_jump beats jump
    r_jump = 1'b1; jump = 1'b1; jr_target = 32'h100; jump_index = 26'h10;
    step();
    r_jump = 1'b0; jump = 1'b0;
    chk("rj_addr", bus.imem_addr, 32'h100);
    chk("rj_drop", if_id_instr, mem_word(32'h40));
    r_jump = 1'b1; jr_target = 32'h1000_0004;
    step();
    r_jump = 1'b0;
    sb.push_back('{instr: mem_word(32'h1000_0004), pc4: 32'h1000_0008});
    step();
    pop_chk("rj2");
    jump = 1'b1; jump_index = 26'h10;
    step();
    jump = 1'b0;
    chk("j_addr", bus.imem_addr, 32'h1000_0040);

    // Flush overrides stall
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_instr", if_id_instr, 32'd0);
    chk("fl_opcode", {26'd0, opcode}, 32'd0);
    chk("fl_funct", {26'd0, funct}, 32'd0);
    chk("fl_valid", {31'd0, if_id_valid}, 32'd0);
    chk("fl_pc4", if_id_pc4, 32'h1000_0008);
    stall = 1'b0;
    sb.push_back('{instr: mem_word(32'h1000_0040), pc4: 32'h1000_0044});
    step();
    pop_chk("fl_release");

    // PC wrap
    r_jump = 1'b1; jr_target = 32'hFFFF_FFFC;
    step();
    r_jump = 1'b0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    sb.push_back('{instr: mem_word(32'hFFFF_FFFC), pc4: 32'h0});
    step();
    pop_chk("wrap");
    chk("wrap_next", bus.imem_addr, 32'h0);

    // Reset mid-request
    bus.imem_ready = 1'b0;
    step();
    chk("pend_req", {31'd0, bus.imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("arst_instr", if_id_instr, 32'd0);
    chk("arst_pc4", if_id_pc4, 32'd0);
    chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    rst = 1'b0; bus.imem_ready = 1'b1;
    step();
    chk("restart_addr", bus.imem_addr, 32'h0);
    chk("restart_req", {31'd0, bus.imem_req}, 32'd1);
    sb.push_back('{instr: mem_word(32'h0), pc4: 32'h4});
    step();
    pop_chk("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
